// File: rtl/frame_arb_pkg.sv
// Shared types and helpers for the frame FIFO arbiter.
package frame_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StXfer,
    StDrain
  } state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_width(int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_fifo_arbiter_rr_pick.sv
// Round-robin picker: first request at or above ptr, wrapping to 0.
module rr_pick
  import frame_arb_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned IDX_W = ch_idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx
);

  int unsigned cand;
  logic        found;

  // Scan upward from ptr; the first requesting channel wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        pick[cand]  = 1'b1;
        pick_idx    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/frame_fifo_arbiter.sv
// Frame-granular round-robin arbiter feeding a shared readout FIFO.
module frame_fifo_arbiter
  import frame_arb_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WATCHDOG   = 4096
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       RUN_EN,
  input  logic                       FIFO_PROG_FULL,
  input  logic [N_CH-1:0]            REQ,
  input  logic [N_CH-1:0]            CH_VALID,
  input  logic [N_CH-1:0]            CH_LAST,
  input  logic [N_CH*DATA_WIDTH-1:0] CH_DATA,
  output logic [N_CH-1:0]            CH_READY,
  output logic [DATA_WIDTH-1:0]      FIFO_DIN,
  output logic                       FIFO_WR,
  output logic [N_CH-1:0]            GRANT,
  output logic                       BUSY,
  output logic                       FRAME_DONE,
  output logic [15:0]                TIMEOUT_CNT,
  output logic [31:0]                FRAME_CNT
);

  localparam int unsigned IDX_W = ch_idx_width(N_CH);
  localparam int unsigned WD_W  = $clog2(WATCHDOG + 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [N_CH-1:0]       grant_q, grant_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [15:0]           timeout_q, timeout_d;
  logic [31:0]           frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;

  logic [N_CH-1:0]       pick;
  logic [IDX_W-1:0]      pick_idx;
  logic                  hs;
  logic                  hs_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IDX_W-1:0]      next_ptr;

  rr_pick #(
    .N_CH (N_CH)
  ) u_rr_pick (
    .req      (REQ),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Ready comes only from registered state, so no valid->ready loop exists.
  assign CH_READY = (state_q == StXfer || state_q == StDrain) ? grant_q : '0;
  assign hs       = |(CH_VALID & CH_READY);
  assign hs_last  = |(CH_VALID & CH_LAST & CH_READY);
  assign sel_data = CH_DATA[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr = (gidx_q == IDX_W'(N_CH - 1)) ? '0 : gidx_q + 1'b1;

  assign GRANT       = grant_q;
  assign BUSY        = (state_q != StIdle);
  assign FIFO_DIN    = din_q;
  assign FIFO_WR     = wr_q;
  assign FRAME_DONE  = done_q;
  assign TIMEOUT_CNT = timeout_q;
  assign FRAME_CNT   = frame_cnt_q;

  // Next-state: run control and prog-full are only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    frame_cnt_d = frame_cnt_q;
    din_d       = din_q;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (RUN_EN && !FIFO_PROG_FULL && (|REQ)) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (|REQ) begin
          state_d = StXfer;
          grant_d = pick;
          gidx_d  = pick_idx;
          wdog_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StXfer: begin
        wdog_d = wdog_q + 1'b1;
        if (hs) begin
          wr_d  = 1'b1;
          din_d = sel_data;
        end
        // A last word in the expiry cycle still completes the frame normally.
        if (hs_last) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 32'd1;
          ptr_d       = next_ptr;
          grant_d     = '0;
          state_d     = StIdle;
        end else if (wdog_q == WD_W'(WATCHDOG - 1)) begin
          timeout_d = sat_inc16(timeout_q);
          state_d   = StDrain;
        end
      end
      StDrain: begin
        if (hs_last) begin
          ptr_d   = next_ptr;
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and the registered FIFO write port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      wdog_q      <= '0;
      timeout_q   <= '0;
      frame_cnt_q <= '0;
      din_q       <= '0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
      din_q       <= din_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_frame_fifo_arbiter.sv
// Directed bench for frame_fifo_arbiter: grant table plus multi-cycle sequences.
module tb_frame_fifo_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int WD  = 16;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             RUN_EN;
  logic             FIFO_PROG_FULL;
  logic [NCH-1:0]   REQ, CH_VALID, CH_LAST, CH_READY, GRANT;
  logic [NCH*DW-1:0] CH_DATA;
  logic [DW-1:0]    FIFO_DIN;
  logic             FIFO_WR, BUSY, FRAME_DONE;
  logic [15:0]      TIMEOUT_CNT;
  logic [31:0]      FRAME_CNT;

  frame_fifo_arbiter #(
    .N_CH       (NCH),
    .DATA_WIDTH (DW),
    .WATCHDOG   (WD)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .RUN_EN         (RUN_EN),
    .FIFO_PROG_FULL (FIFO_PROG_FULL),
    .REQ            (REQ),
    .CH_VALID       (CH_VALID),
    .CH_LAST        (CH_LAST),
    .CH_DATA        (CH_DATA),
    .CH_READY       (CH_READY),
    .FIFO_DIN       (FIFO_DIN),
    .FIFO_WR        (FIFO_WR),
    .GRANT          (GRANT),
    .BUSY           (BUSY),
    .FRAME_DONE     (FRAME_DONE),
    .TIMEOUT_CNT    (TIMEOUT_CNT),
    .FRAME_CNT      (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Source model: each channel offers `left` frames of `len` words, valid held high.
  int len [NCH];
  int pos [NCH];
  int left[NCH];
  int fno [NCH];
  bit use_model;

  logic [31:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] exp_q[$];
  int          grant_ord[$];
  int          cyc;
  int          done_cnt;
  bit          proto_bad;
  logic [NCH-1:0] prev_grant;

  typedef struct {
    logic           run_en;
    logic           pf;
    logic [NCH-1:0] req;
    logic [NCH-1:0] exp_grant;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [31:0] word(int ch, int f, int i);
    return (32'(ch) << 24) | (32'(f) << 16) | 32'(i);
  endfunction

  function automatic int ch_of(logic [NCH-1:0] oh);
    for (int c = 0; c < NCH; c++) if (oh[c]) return c;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_stream(string name);
    int bad;
    check({name, "_len"}, got_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: word %0d got %0h expected %0h", name, bad, got_q[bad], exp_q[bad]);
    end
  endtask

  task automatic exp_frame(int ch, int f, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(word(ch, f, i));
  endtask

  task automatic drive_model();
    for (int c = 0; c < NCH; c++) begin
      REQ[c]      = (left[c] > 0);
      CH_VALID[c] = (left[c] > 0);
      CH_LAST[c]  = (left[c] > 0) && (pos[c] == len[c] - 1);
      CH_DATA[c*DW +: DW] = word(c, fno[c], pos[c]);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    grant_ord.delete();
    done_cnt = 0;
  endtask

  // One clock: handshake seen mid-cycle, outputs sampled 1 time unit after the edge.
  task automatic step();
    logic [NCH-1:0] hs;
    @(negedge CLK);
    hs = CH_READY & CH_VALID;
    if (((CH_READY & ~GRANT) != 0) || ($countones(GRANT) > 1)) proto_bad = 1'b1;
    @(posedge CLK);
    #1;
    cyc++;
    if (use_model) begin
      for (int c = 0; c < NCH; c++) begin
        if (hs[c]) begin
          if (pos[c] == len[c] - 1) begin
            pos[c] = 0;
            left[c]--;
            fno[c]++;
          end else begin
            pos[c]++;
          end
        end
      end
      drive_model();
    end
    if (FIFO_WR) begin
      got_q.push_back(FIFO_DIN);
      got_cyc.push_back(cyc);
    end
    if (FRAME_DONE) begin
      done_cnt++;
      if (!FIFO_WR) proto_bad = 1'b1;
    end
    if (GRANT != 0 && prev_grant == 0) grant_ord.push_back(ch_of(GRANT));
    prev_grant = GRANT;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    RUN_EN = 1'b1;
    FIFO_PROG_FULL = 1'b0;
    use_model = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      len[c] = 1; pos[c] = 0; left[c] = 0; fno[c] = 0;
    end
    drive_model();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    prev_grant = '0;
    clear_logs();
  endtask

  initial begin
    int g, k, base;
    bit cont_bad;
    cyc = 0;
    proto_bad = 1'b0;
    RST_N = 1'b1;
    RUN_EN = 1'b0;
    FIFO_PROG_FULL = 1'b0;
    REQ = '0; CH_VALID = '0; CH_LAST = '0; CH_DATA = '0;
    #2;
    RST_N = 1'b0;
    #3;
    check("rst_fifo_wr", FIFO_WR, 0);
    check("rst_grant", GRANT, 0);
    check("rst_ready", CH_READY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_frame_done", FRAME_DONE, 0);
    check("rst_fifo_din", FIFO_DIN, 0);
    check("rst_timeout_cnt", TIMEOUT_CNT, 0);
    check("rst_frame_cnt", FRAME_CNT, 0);

    // ---- Grant table: one-word frames, ptr evolves from 0 ----
    do_reset();
    use_model = 1'b0;
    tbl[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[1] = '{1'b0, 1'b0, 4'b1111, 4'b0000};
    tbl[2] = '{1'b1, 1'b1, 4'b1111, 4'b0000};
    tbl[3] = '{1'b1, 1'b0, 4'b1111, 4'b0001};
    tbl[4] = '{1'b1, 1'b0, 4'b1111, 4'b0010};
    tbl[5] = '{1'b1, 1'b0, 4'b1001, 4'b1000};
    tbl[6] = '{1'b1, 1'b0, 4'b0110, 4'b0010};
    tbl[7] = '{1'b1, 1'b0, 4'b0011, 4'b0001};
    tbl[8] = '{1'b1, 1'b0, 4'b0100, 4'b0100};
    tbl[9] = '{1'b1, 1'b0, 4'b0001, 4'b0001};
    for (int i = 0; i < 10; i++) begin
      RUN_EN = tbl[i].run_en;
      FIFO_PROG_FULL = tbl[i].pf;
      REQ = tbl[i].req;
      CH_VALID = tbl[i].req;
      CH_LAST = '1;
      for (int c = 0; c < NCH; c++) CH_DATA[c*DW +: DW] = word(c, 9, i);
      g = 0;
      for (int n = 0; n < 5 && g == 0; n++) begin
        step();
        g = int'(GRANT);
      end
      check($sformatf("tbl_grant_%0d", i), g, tbl[i].exp_grant);
      if (g != 0) begin
        step();
        check($sformatf("tbl_wr_%0d", i), FIFO_WR, 1);
        check($sformatf("tbl_din_%0d", i), FIFO_DIN, word(ch_of(tbl[i].exp_grant), 9, i));
      end
      REQ = '0; CH_VALID = '0;
      repeat (2) step();
    end
    check("tbl_writes", got_q.size(), 7);
    check("tbl_frame_cnt", FRAME_CNT, 7);
    check("tbl_done_cnt", done_cnt, 7);

    // ---- Ch0 and ch2 five-word frames; ptr then sits at 3 ----
    do_reset();
    left[0] = 1; len[0] = 5;
    left[2] = 1; len[2] = 5;
    drive_model();
    repeat (25) step();
    exp_frame(0, 0, 5);
    exp_frame(2, 0, 5);
    compare_stream("s1_stream");
    check("s1_frame_cnt", FRAME_CNT, 2);
    check("s1_done_cnt", done_cnt, 2);
    grant_ord.delete();
    left[1] = 1; len[1] = 1;
    left[3] = 1; len[3] = 1;
    drive_model();
    repeat (12) step();
    check("s1_ptr3_first", (grant_ord.size() > 0) ? grant_ord[0] : -1, 3);

    // ---- All channels, 3-word frames: order 0,1,2,3,0 with 2-cycle gaps ----
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      left[c] = 1; len[c] = 3;
    end
    left[0] = 2;
    drive_model();
    repeat (40) step();
    exp_frame(0, 0, 3); exp_frame(1, 0, 3); exp_frame(2, 0, 3);
    exp_frame(3, 0, 3); exp_frame(0, 1, 3);
    compare_stream("s2_stream");
    check("s2_grants", grant_ord.size(), 5);
    if (grant_ord.size() == 5)
      check("s2_order", {grant_ord[0][7:0], grant_ord[1][7:0], grant_ord[2][7:0],
                         grant_ord[3][7:0]} , 32'h00010203);
    check("s2_frame_cnt", FRAME_CNT, 5);
    if (got_cyc.size() == 15) begin
      cont_bad = 1'b0;
      for (int f = 0; f < 5; f++) begin
        base = 3 * f;
        if (got_cyc[base+1] - got_cyc[base] != 1 || got_cyc[base+2] - got_cyc[base+1] != 1)
          cont_bad = 1'b1;
      end
      check("s2_contiguous", cont_bad, 0);
      for (int f = 1; f < 5; f++)
        check($sformatf("s2_gap_%0d", f), got_cyc[3*f] - got_cyc[3*f-1], 3);
    end

    // ---- Prog-full rises mid-frame: frame completes, then no new grant ----
    do_reset();
    left[1] = 1; len[1] = 8;
    left[2] = 1; len[2] = 2;
    drive_model();
    k = 0;
    while (got_q.size() < 2 && k < 20) begin
      step();
      k++;
    end
    check("s3_started", got_q.size() >= 2, 1);
    FIFO_PROG_FULL = 1'b1;
    repeat (25) step();
    exp_frame(1, 0, 8);
    compare_stream("s3_stream");
    check("s3_idle_busy", BUSY, 0);
    check("s3_idle_grant", GRANT, 0);
    FIFO_PROG_FULL = 1'b0;
    repeat (10) step();
    exp_frame(2, 0, 2);
    compare_stream("s3_after_release");

    // ---- Run enable drops mid-frame ----
    do_reset();
    left[0] = 1; len[0] = 4;
    left[1] = 1; len[1] = 2;
    drive_model();
    k = 0;
    while (got_q.size() < 1 && k < 10) begin
      step();
      k++;
    end
    check("s4_started", got_q.size() >= 1, 1);
    RUN_EN = 1'b0;
    repeat (20) step();
    exp_frame(0, 0, 4);
    compare_stream("s4_stream");
    check("s4_busy", BUSY, 0);
    check("s4_frame_cnt", FRAME_CNT, 1);

    // ---- Watchdog: 21-word ch3 frame, only 16 words reach the FIFO ----
    do_reset();
    left[3] = 1; len[3] = 21;
    drive_model();
    repeat (40) step();
    exp_frame(3, 0, 16);
    compare_stream("s5_stream");
    check("s5_timeout_cnt", TIMEOUT_CNT, 1);
    check("s5_done_cnt", done_cnt, 0);
    check("s5_frame_cnt", FRAME_CNT, 0);
    check("s5_drained", left[3], 0);
    check("s5_busy", BUSY, 0);
    grant_ord.delete();
    left[0] = 1; len[0] = 1;
    left[3] = 1; len[3] = 1;
    drive_model();
    repeat (12) step();
    check("s5_ptr0_first", (grant_ord.size() > 0) ? grant_ord[0] : -1, 0);

    // ---- Reset during transfer ----
    do_reset();
    left[1] = 1; len[1] = 8;
    drive_model();
    k = 0;
    while (got_q.size() < 3 && k < 10) begin
      step();
      k++;
    end
    check("s6_started", got_q.size() >= 3, 1);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("s6_rst_wr", FIFO_WR, 0);
    check("s6_rst_grant", GRANT, 0);
    check("s6_rst_ready", CH_READY, 0);
    for (int c = 0; c < NCH; c++) begin
      pos[c] = 0; left[c] = 0; fno[c] = 0;
    end
    drive_model();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    prev_grant = '0;
    clear_logs();
    left[2] = 1; len[2] = 3;
    drive_model();
    repeat (10) step();
    exp_frame(2, 0, 3);
    compare_stream("s6_stream");
    check("s6_grant", (grant_ord.size() == 1) ? grant_ord[0] : -1, 2);

    check("protocol_ready_done", proto_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
